// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO on the host side.
// The FIFO allows back-to-back frames with no idle gap between them.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [BaudW-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;

  logic push;
  logic pop;
  logic fifo_nonempty;
  logic bit_done;

  assign fifo_nonempty = (count_q != '0);
  assign tx_ready      = (count_q != CntFull);
  assign push          = tx_valid && tx_ready;
  assign bit_done      = (baud_cnt_q == BaudMax);
  // The FSM only consumes a byte when it starts a frame.
  assign pop           = fifo_nonempty &&
                         ((state_q == StIdle) || ((state_q == StStop) && bit_done));
  assign tx            = tx_q;
  assign busy          = (state_q != StIdle) || fifo_nonempty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      tx_q       <= 1'b1;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q       <= 1'b1;
          baud_cnt_q <= '0;
          if (fifo_nonempty) begin
            shift_q   <= mem_q[rd_ptr_q];
            bit_idx_q <= '0;
            tx_q      <= 1'b0;
            state_q   <= StStart;
          end
        end
        StStart: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            tx_q       <= shift_q[0];
            state_q    <= StData;
          end else begin
            baud_cnt_q <= baud_cnt_q + BaudW'(1);
          end
        end
        StData: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            shift_q    <= shift_q >> 1;
            bit_idx_q  <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              tx_q <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + BaudW'(1);
          end
        end
        StStop: begin
          if (bit_done) begin
            baud_cnt_q <= '0;
            if (fifo_nonempty) begin
              shift_q   <= mem_q[rd_ptr_q];
              bit_idx_q <= '0;
              tx_q      <= 1'b0;
              state_q   <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + BaudW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a line monitor decodes frames and compares them
// against a scoreboard of accepted bytes; timing checks are done inline.
module tb_uart_tx;

  localparam int unsigned CA = 4;
  localparam int unsigned CB = 2;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_valid_a, tx_valid_b;
  logic       tx_ready_a, tx_ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] sb[$];
  int         start_times[$];
  logic       mon_busy = 1'b0;

  int         nst, s0, t, idx, n_acc;
  int         acc[7];
  logic       hi_ok;
  logic [9:0] frame_b;
  logic [7:0] lb[5];

  uart_tx #(.CLKS_PER_BIT(CA), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(rst_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .tx(tx_a), .busy(busy_a)
  );

  uart_tx #(.CLKS_PER_BIT(CB), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(rst_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .tx(tx_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial monitor on dut_a: every frame is compared against the oldest scoreboard byte.
  initial begin : monitor
    logic [9:0] frame;
    logic       obs;
    logic       ab;
    forever begin
      @(posedge clk); #1;
      if (rst_a === 1'b0 && tx_a === 1'b0) begin
        mon_busy = 1'b1;
        ab = 1'b0;
        start_times.push_back(cyc);
        chk("spurious_start", 32'(sb.size() > 0), 32'd1);
        frame = (sb.size() > 0) ? {1'b1, sb.pop_front(), 1'b0} : {1'b1, 8'h00, 1'b0};
        for (int b = 0; b < 10 && !ab; b++) begin
          obs = frame[b];
          for (int k = 0; k < int'(CA) && !ab; k++) begin
            if (b != 0 || k != 0) begin
              @(posedge clk); #1;
            end
            if (rst_a === 1'b1) ab = 1'b1;
            else if (tx_a !== frame[b]) obs = tx_a;
          end
          if (!ab) chk($sformatf("frame_%02h_bit%0d", frame[8:1], b), 32'(obs), 32'(frame[b]));
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    tx_valid_a = 1'b1;
    tx_data_a  = b;
    while (!tx_ready_a && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_timeout", 32'(tx_ready_a), 32'd1);
    sb.push_back(b);
    @(posedge clk); #1;
    tx_valid_a = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    int w;
    w = 0;
    while (start_times.size() < n && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("start_timeout", 32'(start_times.size() >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((busy_a || mon_busy) && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("idle_timeout", 32'(busy_a || mon_busy), 32'd0);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    tx_valid_a = 1'b0; tx_valid_b = 1'b0;
    tx_data_a = 8'h00; tx_data_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    chk("reset_tx", 32'(tx_a), 32'd1);
    chk("reset_ready", 32'(tx_ready_a), 32'd1);
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_tx_b", 32'(tx_b), 32'd1);

    // Single byte: start one cycle after acceptance, busy drops 40 cycles later.
    nst = start_times.size();
    send(8'hA5);
    s0 = cyc;
    wait_starts(nst + 1);
    chk("start_latency", 32'(start_times[nst]), 32'(s0 + 1));
    t = 0;
    while (busy_a && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("busy_fall", 32'(cyc), 32'(start_times[nst] + 40));
    wait_idle();

    // Back-to-back frames must abut exactly.
    nst = start_times.size();
    send(8'h00);
    send(8'hFF);
    wait_starts(nst + 2);
    chk("b2b_gap", 32'(start_times[nst + 1] - start_times[nst]), 32'd40);
    wait_idle();

    // FIFO full: hold valid with 0x01..0x06.
    idx = 1; t = 0;
    tx_valid_a = 1'b1;
    tx_data_a  = 8'd1;
    while (idx <= 6 && t < 1000) begin
      if (idx == 6 && cyc == acc[5]) chk("full_ready_low", 32'(tx_ready_a), 32'd0);
      if (tx_ready_a) begin
        sb.push_back(tx_data_a);
        acc[idx] = cyc + 1;
        idx++;
      end
      @(posedge clk); #1;
      t++;
      tx_data_a = 8'(idx);
    end
    tx_valid_a = 1'b0;
    n_acc = idx - 1;
    chk("full_accepted", 32'(n_acc), 32'd6);
    chk("full_first5", 32'(acc[5] - acc[1]), 32'd4);
    chk("full_sixth", 32'(acc[6] - acc[1]), 32'd42);
    wait_idle();
    chk("full_sb_drained", 32'(sb.size()), 32'd0);

    // Reset during data bit 3 of 0x3C with two bytes queued.
    nst = start_times.size();
    send(8'h3C);
    send(8'h11);
    send(8'h22);
    wait_starts(nst + 1);
    s0 = start_times[nst];
    t = 0;
    while (cyc < s0 + 17 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    rst_a = 1'b1;
    @(posedge clk); #2;
    chk("midreset_tx", 32'(tx_a), 32'd1);
    chk("midreset_busy", 32'(busy_a), 32'd0);
    chk("midreset_ready", 32'(tx_ready_a), 32'd1);
    rst_a = 1'b0;
    sb.delete();
    hi_ok = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      if (tx_a !== 1'b1) hi_ok = 1'b0;
    end
    chk("midreset_line_high", 32'(hi_ok), 32'd1);
    chk("midreset_no_start", 32'(start_times.size()), 32'(nst + 1));

    // Loopback through the bench's receiver model.
    lb[0] = 8'h55; lb[1] = 8'hAA; lb[2] = 8'h00; lb[3] = 8'hFF; lb[4] = 8'h81;
    for (int i = 0; i < 5; i++) send(lb[i]);
    wait_idle();
    chk("loopback_sb_drained", 32'(sb.size()), 32'd0);

    // Minimum divider on dut_b: 0x96, two cycles per bit.
    frame_b = {1'b1, 8'h96, 1'b0};
    tx_valid_b = 1'b1;
    tx_data_b  = 8'h96;
    @(posedge clk); #1;
    tx_valid_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mindiv_cyc%0d", i), 32'(tx_b), 32'(frame_b[i / 2]));
      if (i == 19) chk("mindiv_busy_last", 32'(busy_b), 32'd1);
    end
    @(posedge clk); #1;
    chk("mindiv_idle_tx", 32'(tx_b), 32'd1);
    chk("mindiv_busy_end", 32'(busy_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
